// File: rtl/wordline_encoder_64to6.sv
// Registered 64-to-6 encoder for active-low wordline vectors with valid/ready on both sides.
// Define ENC_MULTI_DRAIN_EN to drain one beat per hit; otherwise each vector yields a single beat.
module wordline_encoder_64to6 #(
   parameter int N_ADDR = 6,
   parameter int N_WL   = 64
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [N_WL-1:0]   in_wordline,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [N_ADDR-1:0] out_addr,
   output logic              out_last,
   output logic              out_empty,
   output logic [N_ADDR:0]   out_hits
);

   typedef enum logic {IDLE, DRAIN} state_t;

   state_t          state, state_nxt;
   logic            vld_p1;
   logic            beat;
   logic            accept;
   logic            last_c;
   logic            empty_p1;
   logic [N_ADDR:0] hits_p1;

   function automatic logic [N_ADDR-1:0] lowest_hit(input logic [N_WL-1:0] v);
      logic [N_ADDR-1:0] r;
      r = '0;
      for (int i = N_WL - 1; i >= 0; i--) begin
         if (v[i]) r = N_ADDR'(i);
      end
      return r;
   endfunction

   function automatic logic [N_ADDR:0] hit_count(input logic [N_WL-1:0] v);
      logic [N_ADDR:0] c;
      c = '0;
      for (int i = 0; i < N_WL; i++) begin
         c = c + (N_ADDR + 1)'(v[i]);
      end
      return c;
   endfunction

   assign vld_p1 = (state == DRAIN);
   assign beat   = vld_p1 & out_ready;
   assign accept = in_valid & in_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // A last-beat transfer frees the slot in the same cycle, so a waiting vector loads without a bubble.
   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) state_nxt = DRAIN;
         end
         DRAIN: begin
            in_ready = out_ready & last_c;
            if (beat & last_c & ~in_valid) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // ---- p1: capture stage ----
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hits_p1  <= '0;
         empty_p1 <= 1'b0;
      end else if (accept) begin
         hits_p1  <= hit_count(~in_wordline);
         empty_p1 <= &in_wordline;
      end
   end

`ifdef ENC_MULTI_DRAIN_EN
   logic [N_WL-1:0] pending_p1;

   // Each transfer retires the lowest pending hit: v & (v-1) clears the lowest set bit.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)         pending_p1 <= '0;
      else if (accept) pending_p1 <= ~in_wordline;
      else if (beat)   pending_p1 <= pending_p1 & (pending_p1 - N_WL'(1));
   end

   assign out_addr = lowest_hit(pending_p1);
   assign last_c   = ((pending_p1 & (pending_p1 - N_WL'(1))) == '0);
`else
   logic [N_ADDR-1:0] addr_p1;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)         addr_p1 <= '0;
      else if (accept) addr_p1 <= lowest_hit(~in_wordline);
   end

   assign out_addr = addr_p1;
   assign last_c   = 1'b1;
`endif

   assign out_valid = vld_p1;
   assign out_last  = vld_p1 & last_c;
   assign out_empty = empty_p1;
   assign out_hits  = hits_p1;

endmodule

// File: tb/tb_wordline_encoder_64to6.sv
// Directed self-checking bench for wordline_encoder_64to6 (either build of ENC_MULTI_DRAIN_EN).
module tb_wordline_encoder_64to6;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [63:0] in_wordline;
   logic        out_valid;
   logic        out_ready;
   logic [5:0]  out_addr;
   logic        out_last;
   logic        out_empty;
   logic [6:0]  out_hits;

   int checks = 0;
   int errors = 0;

   wordline_encoder_64to6 dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_wordline (in_wordline),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_addr    (out_addr),
      .out_last    (out_last),
      .out_empty   (out_empty),
      .out_hits    (out_hits)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   function automatic logic [63:0] decode(input logic [5:0] a);
      logic [63:0] one;
      one = 64'd1;
      return ~(one << a);
   endfunction

   initial begin
      rst         = 1'b1;
      in_valid    = 1'b0;
      out_ready   = 1'b0;
      in_wordline = '1;
      repeat (2) @(posedge clk);
      #2 rst = 1'b0;
      #1;
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_hits", out_hits, 0);

      // Reset in the middle of a 3-hit drain
      tick();
      in_valid    = 1'b1;
      in_wordline = ~((64'd1 << 5) | (64'd1 << 17) | (64'd1 << 63));
      tick();
      in_valid = 1'b0;
      chk("pre_rst_valid", out_valid, 1);
      chk("pre_rst_hits", out_hits, 3);
      #1 rst = 1'b1;
      #1;
      chk("async_rst_valid", out_valid, 0);
      chk("async_rst_addr", out_addr, 0);
      chk("async_rst_last", out_last, 0);
      chk("async_rst_empty", out_empty, 0);
      chk("async_rst_hits", out_hits, 0);
      tick();
      rst = 1'b0;
      #1;
      chk("post_rst_in_ready", in_ready, 1);
      chk("post_rst_valid", out_valid, 0);

      // One-hot sweep, one vector per cycle
      tick();
      out_ready   = 1'b1;
      in_valid    = 1'b1;
      in_wordline = decode(6'd0);
      for (int i = 0; i < 64; i++) begin
         tick();
         chk("sweep_valid", out_valid, 1);
         chk("sweep_addr", out_addr, i);
         chk("sweep_last", out_last, 1);
         chk("sweep_hits", out_hits, 1);
         chk("sweep_in_ready", in_ready, 1);
         if (i < 63) in_wordline = decode(6'(i + 1));
         else        in_valid = 1'b0;
      end
      tick();
      chk("sweep_done_valid", out_valid, 0);

      // Multi-hit vector {5,17,63}
      in_valid    = 1'b1;
      in_wordline = ~((64'd1 << 5) | (64'd1 << 17) | (64'd1 << 63));
      tick();
      in_valid    = 1'b0;
      in_wordline = 64'h0;
      chk("multi_b0_addr", out_addr, 5);
      chk("multi_b0_hits", out_hits, 3);
`ifdef ENC_MULTI_DRAIN_EN
      chk("multi_b0_last", out_last, 0);
      chk("multi_b0_in_ready", in_ready, 0);
      tick();
      chk("multi_b1_addr", out_addr, 17);
      chk("multi_b1_last", out_last, 0);
      chk("multi_b1_hits", out_hits, 3);
      tick();
      chk("multi_b2_addr", out_addr, 63);
      chk("multi_b2_last", out_last, 1);
      chk("multi_b2_hits", out_hits, 3);
`else
      chk("multi_b0_last", out_last, 1);
`endif
      tick();
      chk("multi_done_valid", out_valid, 0);

      // Backpressure on {2,40}
      out_ready   = 1'b0;
      in_valid    = 1'b1;
      in_wordline = ~((64'd1 << 2) | (64'd1 << 40));
      tick();
      in_valid    = 1'b0;
      in_wordline = decode(6'd9);
      for (int k = 0; k < 4; k++) begin
         chk("bp_valid", out_valid, 1);
         chk("bp_addr", out_addr, 2);
         chk("bp_in_ready", in_ready, 0);
         chk("bp_hits", out_hits, 2);
         tick();
      end
      chk("bp_hold_addr", out_addr, 2);
      out_ready = 1'b1;
      #1;
`ifdef ENC_MULTI_DRAIN_EN
      chk("bp_rel_in_ready", in_ready, 0);
      tick();
      chk("bp_b1_addr", out_addr, 40);
      chk("bp_b1_last", out_last, 1);
      chk("bp_b1_hits", out_hits, 2);
`else
      chk("bp_rel_in_ready", in_ready, 1);
`endif
      tick();
      chk("bp_done_valid", out_valid, 0);

      // Empty vector
      in_valid    = 1'b1;
      in_wordline = '1;
      tick();
      in_valid = 1'b0;
      chk("empty_valid", out_valid, 1);
      chk("empty_flag", out_empty, 1);
      chk("empty_addr", out_addr, 0);
      chk("empty_last", out_last, 1);
      chk("empty_hits", out_hits, 0);
      tick();
      chk("empty_done_valid", out_valid, 0);

      // Full vector: every line hit
      in_valid    = 1'b1;
      in_wordline = '0;
      tick();
      in_valid = 1'b0;
      chk("full_hits", out_hits, 64);
      chk("full_empty", out_empty, 0);
`ifdef ENC_MULTI_DRAIN_EN
      for (int k = 0; k < 64; k++) begin
         chk("full_addr", out_addr, k);
         chk("full_last", out_last, (k == 63) ? 1 : 0);
         tick();
      end
`else
      chk("full_addr", out_addr, 0);
      chk("full_last", out_last, 1);
      tick();
`endif
      chk("full_done_valid", out_valid, 0);

      // Decoder loopback, isolated vectors, with input changes during DRAIN ignored
      for (int a = 0; a < 64; a++) begin
         in_valid    = 1'b1;
         in_wordline = decode(6'(a));
         tick();
         in_valid    = 1'b0;
         in_wordline = decode(6'(63 - a));
         chk("loop_addr", out_addr, a);
         chk("loop_hits", out_hits, 1);
         tick();
      end
      chk("loop_done_valid", out_valid, 0);
      chk("loop_done_in_ready", in_ready, 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
